// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES types, inverse S-box table and flat<->matrix
//               conversion helpers for the AES-128 inverse-round datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    typedef logic [7:0] byte_t;
    // State matrix indexed [row][col]
    typedef logic [3:0][3:0][7:0] state_t;

    localparam byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Flat byte i (bits [127-8i -: 8]) lands at row i%4, column i/4.
    function automatic state_t to_matrix(input logic [127:0] w);
        state_t m;
        m = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                m[r[1:0]][c[1:0]] = w[127 - 8 * (4 * c + r) -: 8];
            end
        end
        return m;
    endfunction

    function automatic logic [127:0] to_flat(input state_t m);
        logic [127:0] w;
        w = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w[127 - 8 * (4 * c + r) -: 8] = m[r[1:0]][c[1:0]];
            end
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_sbox.sv
`default_nettype none
// ============================================================================
// Module      : aes_inv_sbox
// Description : Combinational AES inverse S-box lookup (one byte).
//   in_i  [7:0] : input byte
//   out_o [7:0] : InvSubBytes(in_i)
// Revision    : 1.0 - initial release
// ============================================================================
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    assign out_o = INV_SBOX[in_i];

endmodule
`default_nettype wire

// File: rtl/aes_dec_first_round.sv
`default_nettype none
// ============================================================================
// Module      : aes_dec_first_round
// Description : Registered first stage of AES-128 decryption:
//               AddRoundKey(k10) -> InvShiftRows -> InvSubBytes.
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   in_valid   : state_in/round_key valid this cycle
//   state_in   : 128-bit flat ciphertext/state
//   round_key  : 128-bit flat round key
//   out_valid  : state_out/ark_out hold a new result
//   state_out  : InvSubBytes(InvShiftRows(state_in ^ round_key))
//   ark_out    : state_in ^ round_key
// Revision    : 1.0 - initial release
// ============================================================================
module aes_dec_first_round
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    output logic         out_valid,
    output logic [127:0] state_out,
    output logic [127:0] ark_out
);

    logic [127:0] w_ark;
    state_t       w_ark_m;
    state_t       w_shr_m;
    state_t       w_sub_m;

    logic         valid_q, valid_d;
    logic [127:0] state_q, state_d;
    logic [127:0] ark_q,   ark_d;

    assign w_ark   = state_in ^ round_key;
    assign w_ark_m = to_matrix(w_ark);

    // InvShiftRows is pure wiring: row r rotates right by r columns.
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign w_shr_m[r][c] = w_ark_m[r][(c - r + 4) % 4];

            aes_inv_sbox u_inv_sbox (
                .in_i  (w_shr_m[r][c]),
                .out_o (w_sub_m[r][c])
            );
        end
    end

    // Idle cycles drop valid but keep the last result visible.
    always_comb begin
        valid_d = in_valid;
        state_d = state_q;
        ark_d   = ark_q;
        if (in_valid) begin
            state_d = to_flat(w_sub_m);
            ark_d   = w_ark;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            state_q <= '0;
            ark_q   <= '0;
        end else begin
            valid_q <= valid_d;
            state_q <= state_d;
            ark_q   <= ark_d;
        end
    end

    assign out_valid = valid_q;
    assign state_out = state_q;
    assign ark_out   = ark_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_dec_first_round.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_dec_first_round
// Description : Self-checking bench for aes_dec_first_round. The reference
//               model derives the inverse S-box from GF(2^8) inversion plus
//               the forward affine map, then applies the round steps bytewise.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_dec_first_round;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [127:0] state_in;
    logic [127:0] round_key;
    logic         out_valid;
    logic [127:0] state_out;
    logic [127:0] ark_out;

    int total = 0;
    int bad   = 0;
    bit run_cmp = 0;

    logic [7:0] inv_tab [256];

    logic         exp_valid;
    logic [127:0] exp_state;
    logic [127:0] exp_ark;

    localparam logic [127:0] C1_S   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_K   = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C1_ARK = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    localparam logic [127:0] C1_OUT = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
    localparam logic [127:0] ALL52  = {16{8'h52}};
    localparam logic [127:0] ALL63  = {16{8'h63}};
    localparam logic [127:0] PAT    = 128'h0123456789abcdeffedcba9876543210;

    aes_dec_first_round dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .state_in  (state_in),
        .round_key (round_key),
        .out_valid (out_valid),
        .state_out (state_out),
        .ark_out   (ark_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_inv_tab();
        logic [7:0] x, inv, s;
        for (int xi = 0; xi < 256; xi++) begin
            x   = xi[7:0];
            inv = 8'h00;
            for (int yi = 1; yi < 256; yi++) begin
                if (x != 8'h00 && gmul(x, yi[7:0]) == 8'h01) inv = yi[7:0];
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            inv_tab[s] = x;
        end
    endtask

    function automatic logic [7:0] byte_at(input logic [127:0] w, input int i);
        return w[127 - 8 * i -: 8];
    endfunction

    // Output byte at (row r, col c) takes ARK byte at (r, (c - r) mod 4).
    function automatic logic [127:0] model_out(input logic [127:0] s, input logic [127:0] k);
        logic [127:0] a, o;
        int r, c, src;
        a = s ^ k;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            r   = i % 4;
            c   = i / 4;
            src = r + 4 * ((c - r + 4) % 4);
            o[127 - 8 * i -: 8] = inv_tab[byte_at(a, src)];
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Reference model state: what the outputs must show after each edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_valid <= 1'b0;
            exp_state <= '0;
            exp_ark   <= '0;
        end else begin
            exp_valid <= in_valid;
            if (in_valid) begin
                exp_state <= model_out(state_in, round_key);
                exp_ark   <= state_in ^ round_key;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (run_cmp) begin
            chk("cmp_valid", {127'd0, out_valid}, {127'd0, exp_valid});
            chk("cmp_state", state_out, exp_state);
            chk("cmp_ark",   ark_out,   exp_ark);
        end
    end

    task automatic step(input logic v, input logic [127:0] s, input logic [127:0] k);
        @(negedge clk);
        in_valid  = v;
        state_in  = s;
        round_key = k;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; state_in = '0; round_key = '0;
        build_inv_tab();

        // Pin the model itself against known values
        chk("model_inv63", {120'd0, inv_tab[8'h63]}, 128'h00);
        chk("model_inv00", {120'd0, inv_tab[8'h00]}, 128'h52);
        chk("model_c1",    model_out(C1_S, C1_K), C1_OUT);

        // Reset state, with in_valid high during reset
        @(negedge clk); in_valid = 1'b1; state_in = C1_S; round_key = C1_K;
        @(posedge clk); #2;
        chk("rst_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_state", state_out, 128'd0);
        chk("rst_ark",   ark_out,   128'd0);
        @(negedge clk); rst = 1'b0; in_valid = 1'b0;
        run_cmp = 1'b1;

        step(1'b1, C1_S, C1_K);
        chk("c1_valid", {127'd0, out_valid}, 128'd1);
        chk("c1_ark",   ark_out,   C1_ARK);
        chk("c1_state", state_out, C1_OUT);

        step(1'b1, '0, '0);
        chk("zero_state", state_out, ALL52);
        chk("zero_ark",   ark_out,   128'd0);

        step(1'b1, PAT, PAT);
        chk("cancel_ark",   ark_out,   128'd0);
        chk("cancel_state", state_out, ALL52);

        step(1'b1, ALL63, '0);
        chk("fix63_state", state_out, 128'd0);
        chk("fix63_ark",   ark_out,   ALL63);

        // Idle cycle with garbage on the data inputs: outputs hold
        step(1'b0, PAT, C1_K);
        chk("idle_valid", {127'd0, out_valid}, 128'd0);
        chk("idle_state", state_out, 128'd0);
        chk("idle_ark",   ark_out,   ALL63);

        // Back-to-back stream, then idle
        step(1'b1, C1_S, C1_K);
        step(1'b1, '0, '0);
        step(1'b1, PAT, PAT);
        step(1'b1, ALL63, '0);
        step(1'b0, C1_S, PAT);
        step(1'b0, '0, ALL63);
        chk("hold_state", state_out, 128'd0);

        // Pseudo-random vectors, mixed valid
        for (int n = 0; n < 24; n++) begin
            step($urandom_range(0, 3) != 0,
                 {$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom});
        end

        // Asynchronous reset mid-stream
        step(1'b1, C1_S, C1_K);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", {127'd0, out_valid}, 128'd0);
        chk("arst_state", state_out, 128'd0);
        chk("arst_ark",   ark_out,   128'd0);
        @(posedge clk); #2;
        @(posedge clk); #2;
        @(negedge clk); rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #2;
        chk("post_rst_valid", {127'd0, out_valid}, 128'd0);
        step(1'b1, C1_S, C1_K);
        chk("recap_valid", {127'd0, out_valid}, 128'd1);
        chk("recap_state", state_out, C1_OUT);
        step(1'b0, '0, '0);

        run_cmp = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
